adc_block_accumulator: RTL and testbench

Upstream stage of the SPGD measurement path. Sums a fixed block of 2^LOG2_N signed ADC samples on `adc_clk`, then raises `done` and holds the block sum and mean stable until the downstream done/valid FSM returns its one-cycle clear pulse. It then restarts accumulation immediately. The FSM's `RST` output drives `acc_clr`; `done` drives the FSM's `done` input.

---
 rtl/adc_block_accumulator_pkg.sv | 17 +
 rtl/adc_block_accumulator.sv | 119 +++++++++++
 tb/tb_adc_block_accumulator.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_block_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_block_accumulator_pkg
// Description : Shared SPGD measurement-path widths and state encoding.
// Revision    : 1.0
// ============================================================================
package adc_block_accumulator_pkg;

    localparam int DEFAULT_DATA_W = 14;
    localparam int DEFAULT_LOG2_N = 10;

    localparam logic [1:0] IDLE  = 2'b00;
    localparam logic [1:0] ACCUM = 2'b01;
    localparam logic [1:0] HOLD  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/adc_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : adc_block_accumulator
// Description : Sums 2^LOG2_N signed ADC samples, holds sum/mean until cleared.
// Revision    : 1.0
// ============================================================================
module adc_block_accumulator
    import adc_block_accumulator_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int LOG2_N = DEFAULT_LOG2_N
) (
    input  logic                               adc_clk,
    input  logic                               rst,
    input  logic                               enable,
    input  logic signed [DATA_W-1:0]           adc_dat,
    input  logic                               adc_vld,
    input  logic                               acc_clr,
    output logic                               done,
    output logic signed [DATA_W+LOG2_N-1:0]    sum,
    output logic signed [DATA_W-1:0]           mean,
    output logic        [LOG2_N-1:0]           sample_cnt
);

    localparam int               SUM_W    = DATA_W + LOG2_N;
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    logic [1:0]        state_q, state_d;
    logic [SUM_W-1:0]  acc_q,   acc_d;
    logic [LOG2_N-1:0] cnt_q,   cnt_d;
    logic              done_q,  done_d;
    logic [SUM_W-1:0]  sum_q,   sum_d;
    logic [DATA_W-1:0] mean_q,  mean_d;
    logic [SUM_W-1:0]  w_acc_next;

    always_comb begin
        w_acc_next = acc_q + {{LOG2_N{adc_dat[DATA_W-1]}}, adc_dat};
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        done_d     = done_q;
        sum_d      = sum_q;
        mean_d     = mean_q;

        case (state_q)
            IDLE: begin
                acc_d = '0;
                cnt_d = '0;
                if (enable) begin
                    state_d = ACCUM;
                end
            end

            ACCUM: begin
                if (acc_clr) begin
                    acc_d = '0;
                    cnt_d = '0;
                end else if (!enable) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (adc_vld) begin
                    if (cnt_q == CNT_LAST) begin
                        // Upper bits of the full sum are the floor-shifted mean.
                        sum_d   = w_acc_next;
                        mean_d  = w_acc_next[SUM_W-1:LOG2_N];
                        done_d  = 1'b1;
                        state_d = HOLD;
                        acc_d   = '0;
                        cnt_d   = '0;
                    end else begin
                        acc_d = w_acc_next;
                        cnt_d = cnt_q + LOG2_N'(1);
                    end
                end
            end

            HOLD: begin
                // Disabling alone must not release HOLD; the consumer still needs done.
                if (acc_clr) begin
                    done_d  = 1'b0;
                    state_d = enable ? ACCUM : IDLE;
                end
            end

            default: begin
                state_d = IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge adc_clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            mean_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            mean_q  <= mean_d;
        end
    end

    assign done       = done_q;
    assign sum        = sum_q;
    assign mean       = mean_q;
    assign sample_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_block_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_block_accumulator
// Description : Self-checking bench for adc_block_accumulator with N = 4.
// Revision    : 1.0
// ============================================================================
module tb_adc_block_accumulator;

    localparam int DW = 14;
    localparam int LN = 2;
    localparam int SW = DW + LN;
    localparam int N  = 1 << LN;

    logic                 adc_clk = 1'b0;
    logic                 rst;
    logic                 enable;
    logic signed [DW-1:0] adc_dat;
    logic                 adc_vld;
    logic                 acc_clr;
    logic                 done;
    logic signed [SW-1:0] sum;
    logic signed [DW-1:0] mean;
    logic [LN-1:0]        sample_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int last_sum = 0;

    adc_block_accumulator #(.DATA_W(DW), .LOG2_N(LN)) dut (
        .adc_clk    (adc_clk),
        .rst        (rst),
        .enable     (enable),
        .adc_dat    (adc_dat),
        .adc_vld    (adc_vld),
        .acc_clr    (acc_clr),
        .done       (done),
        .sum        (sum),
        .mean       (mean),
        .sample_cnt (sample_cnt)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic tick();
        @(posedge adc_clk);
        #1;
    endtask

    function automatic int rand_sample();
        return int'($urandom_range(0, 16383)) - 8192;
    endfunction

    function automatic int model_sum(input int s[4]);
        int acc = 0;
        foreach (s[i]) acc += s[i];
        return acc;
    endfunction

    // Mean is the block sum divided by N, rounded toward minus infinity.
    function automatic int model_mean(input int total);
        if (total >= 0) return total / N;
        return -((-total + N - 1) / N);
    endfunction

    task automatic feed4(input int s[4]);
        foreach (s[i]) begin
            adc_vld = 1'b1;
            adc_dat = DW'(s[i]);
            tick();
        end
        adc_vld = 1'b0;
    endtask

    task automatic release_hold();
        acc_clr = 1'b1;
        adc_vld = 1'b0;
        tick();
        acc_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; adc_vld = 1'b0; acc_clr = 1'b0; adc_dat = '0;
        tick(); tick();
        rst = 1'b0;
        n_tests++;
        if (done !== 1'b0 || sum !== '0 || mean !== '0 || sample_cnt !== '0) begin
            n_fail++;
            $display("FAIL reset: done=%b sum=%0d mean=%0d cnt=%0d required 0/0/0/0", done, sum, mean, sample_cnt);
        end
    endtask

    task automatic test_basic();
        int s[4] = '{100, 200, -50, 10};
        enable = 1'b1; adc_vld = 1'b1; adc_dat = DW'(999);
        tick();
        n_tests++;
        if (sample_cnt !== '0) begin
            n_fail++; $display("FAIL enable_transition_cnt: got %0d required 0", sample_cnt);
        end
        foreach (s[i]) begin
            adc_vld = 1'b1; adc_dat = DW'(s[i]);
            tick();
            if (i == 2) begin
                n_tests++;
                if (done !== 1'b0 || sample_cnt !== LN'(3)) begin
                    n_fail++; $display("FAIL basic_pre_done: done=%b cnt=%0d required 0/3", done, sample_cnt);
                end
            end
        end
        adc_vld = 1'b0;
        n_tests++;
        if (done !== 1'b1 || sum !== SW'(260) || mean !== DW'(65) || sample_cnt !== '0) begin
            n_fail++; $display("FAIL basic: done=%b sum=%0d mean=%0d cnt=%0d required 1/260/65/0", done, sum, mean, sample_cnt);
        end
        last_sum = 260;
        release_hold();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL basic_clear: done=%b required 0", done);
        end
    endtask

    task automatic test_extremes();
        feed4('{-8192, -8192, -8192, -8192});
        n_tests++;
        if (sum !== SW'(-32768) || mean !== DW'(-8192)) begin
            n_fail++; $display("FAIL min_block: sum=%0d mean=%0d required -32768/-8192", sum, mean);
        end
        release_hold();
        feed4('{8191, 8191, 8191, 8191});
        n_tests++;
        if (sum !== SW'(32764) || mean !== DW'(8191)) begin
            n_fail++; $display("FAIL max_block: sum=%0d mean=%0d required 32764/8191", sum, mean);
        end
        release_hold();
    endtask

    task automatic test_floor_hold();
        feed4('{-1, 0, 0, 0});
        n_tests++;
        if (sum !== SW'(-1) || mean !== DW'(-1)) begin
            n_fail++; $display("FAIL floor_mean: sum=%0d mean=%0d required -1/-1", sum, mean);
        end
        for (int i = 0; i < 3; i++) begin
            adc_vld = 1'b1; adc_dat = DW'(5000);
            tick();
        end
        adc_vld = 1'b0;
        n_tests++;
        if (sum !== SW'(-1) || done !== 1'b1 || sample_cnt !== '0) begin
            n_fail++; $display("FAIL hold_discard: sum=%0d done=%b cnt=%0d required -1/1/0", sum, done, sample_cnt);
        end
        last_sum = -1;
        release_hold();
    endtask

    task automatic test_clear_restart();
        adc_vld = 1'b1; adc_dat = DW'(7); tick();
        adc_dat = DW'(9); tick();
        acc_clr = 1'b1; adc_dat = DW'(1000); tick();
        acc_clr = 1'b0; adc_vld = 1'b0;
        n_tests++;
        if (sample_cnt !== '0 || done !== 1'b0) begin
            n_fail++; $display("FAIL accum_clear: cnt=%0d done=%b required 0/0", sample_cnt, done);
        end
        feed4('{1, 2, 3, 4});
        n_tests++;
        if (sum !== SW'(10) || mean !== DW'(2)) begin
            n_fail++; $display("FAIL restart_block: sum=%0d mean=%0d required 10/2", sum, mean);
        end
        last_sum = 10;
        release_hold();
    endtask

    task automatic test_enable_hold();
        int s[4];
        int exp_sum;
        foreach (s[i]) s[i] = rand_sample();
        exp_sum = model_sum(s);
        feed4(s);
        enable = 1'b0;
        tick(); tick(); tick();
        n_tests++;
        if (done !== 1'b1 || sum !== SW'(exp_sum)) begin
            n_fail++; $display("FAIL disabled_hold: done=%b sum=%0d required 1/%0d", done, sum, exp_sum);
        end
        release_hold();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++; $display("FAIL disabled_release: done=%b required 0", done);
        end
        adc_vld = 1'b1; adc_dat = DW'(50); acc_clr = 1'b1; tick();
        acc_clr = 1'b0;
        n_tests++;
        if (sample_cnt !== '0 || sum !== SW'(exp_sum) || done !== 1'b0) begin
            n_fail++; $display("FAIL idle_ignores: cnt=%0d sum=%0d done=%b required 0/%0d/0", sample_cnt, sum, done, exp_sum);
        end
        enable = 1'b1; adc_dat = DW'(77); tick();
        foreach (s[i]) s[i] = rand_sample();
        exp_sum = model_sum(s);
        feed4(s);
        n_tests++;
        if (sum !== SW'(exp_sum) || mean !== DW'(model_mean(exp_sum))) begin
            n_fail++; $display("FAIL reenable_block: sum=%0d mean=%0d required %0d/%0d", sum, mean, exp_sum, model_mean(exp_sum));
        end
        last_sum = exp_sum;
        release_hold();
    endtask

    task automatic test_abort();
        adc_vld = 1'b1; adc_dat = DW'(3); tick();
        adc_dat = DW'(4); tick();
        adc_vld = 1'b0;
        n_tests++;
        if (sample_cnt !== LN'(2)) begin
            n_fail++; $display("FAIL partial_cnt: got %0d required 2", sample_cnt);
        end
        enable = 1'b0; tick();
        n_tests++;
        if (sample_cnt !== '0 || done !== 1'b0 || sum !== SW'(last_sum)) begin
            n_fail++; $display("FAIL abort: cnt=%0d done=%b sum=%0d required 0/0/%0d", sample_cnt, done, sum, last_sum);
        end
        enable = 1'b1; tick();
        feed4('{20, 20, 20, -61});
        n_tests++;
        if (sum !== SW'(-1) || mean !== DW'(-1)) begin
            n_fail++; $display("FAIL after_abort: sum=%0d mean=%0d required -1/-1", sum, mean);
        end
    endtask

    task automatic test_rst_midway();
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if (done !== 1'b0 || sum !== '0 || mean !== '0 || sample_cnt !== '0) begin
            n_fail++; $display("FAIL rst_in_hold: done=%b sum=%0d mean=%0d cnt=%0d required 0/0/0/0", done, sum, mean, sample_cnt);
        end
        tick();
        adc_vld = 1'b1; adc_dat = DW'(11); tick(); tick();
        adc_vld = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        n_tests++;
        if (done !== 1'b0 || sum !== '0 || mean !== '0 || sample_cnt !== '0) begin
            n_fail++; $display("FAIL rst_in_accum: done=%b sum=%0d mean=%0d cnt=%0d required 0/0/0/0", done, sum, mean, sample_cnt);
        end
        last_sum = 0;
        tick();
    endtask

    task automatic test_random();
        for (int b = 0; b < 6; b++) begin
            int q[$];
            int total;
            int guard;
            guard = 0;
            while (q.size() < N && guard < 200) begin
                adc_vld = 1'($urandom_range(0, 1));
                adc_dat = DW'(rand_sample());
                if (adc_vld) q.push_back(int'(adc_dat));
                tick();
                guard++;
            end
            adc_vld = 1'b0;
            total = 0;
            foreach (q[i]) total += q[i];
            n_tests++;
            if (done !== 1'b1 || sum !== SW'(total) || mean !== DW'(model_mean(total)) || sample_cnt !== '0) begin
                n_fail++;
                $display("FAIL random_block%0d: done=%b sum=%0d mean=%0d required 1/%0d/%0d", b, done, sum, mean, total, model_mean(total));
            end
            release_hold();
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 4; b++) begin
            int s[4];
            int total;
            for (int k = 0; k < N; k++) begin
                n_tests++;
                if (done !== 1'b0) begin
                    n_fail++; $display("FAIL b2b_accum_done%0d_%0d: done=%b required 0", b, k, done);
                end
                s[k] = rand_sample();
                adc_vld = 1'b1; adc_dat = DW'(s[k]);
                tick();
            end
            total = model_sum(s);
            n_tests++;
            if (sum !== SW'(total) || mean !== DW'(model_mean(total))) begin
                n_fail++; $display("FAIL b2b_sum%0d: sum=%0d mean=%0d required %0d/%0d", b, sum, mean, total, model_mean(total));
            end
            for (int h = 0; h < 3; h++) begin
                n_tests++;
                if (done !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_hold%0d_%0d: done=%b required 1", b, h, done);
                end
                acc_clr = (h == 2);
                adc_dat = DW'(rand_sample());
                tick();
            end
            acc_clr = 1'b0;
        end
        adc_vld = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_extremes();
        test_floor_hold();
        test_clear_restart();
        test_enable_hold();
        test_abort();
        test_rst_midway();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
